// File: rtl/pipeline_pkg.sv
// Shared constants for the ID/EX pipeline register: control-bit positions,
// instruction field slices and the bubble control word.
package pipeline_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 8;

  // ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[1:0]}
  localparam int CTRL_REG_WRITE  = 7;
  localparam int CTRL_MEM_READ   = 6;
  localparam int CTRL_MEM_WRITE  = 5;
  localparam int CTRL_MEM_TO_REG = 4;
  localparam int CTRL_ALU_SRC    = 3;
  localparam int CTRL_REG_DST    = 2;
  localparam int CTRL_ALU_OP     = 0;
  localparam int CTRL_ALU_OP_W   = 2;

  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 16;

  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = 8'h00;

  function automatic logic [DATA_W-1:0] sign_ext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/id_ex_register_if.sv
// ID-side inputs, write-back bypass inputs and EX-side outputs of the ID/EX register.
interface id_ex_register_if;
  import pipeline_pkg::*;

  logic [31:0]       instr_in;
  logic [DATA_W-1:0] pc_in;
  logic              valid_in;
  logic [DATA_W-1:0] rdata1_in;
  logic [DATA_W-1:0] rdata2_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic              wb_we;
  logic [REG_AW-1:0] wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic              flush;

  logic              stall_out;
  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0] ex_pc;
  logic [DATA_W-1:0] ex_op1;
  logic [DATA_W-1:0] ex_op2;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_dest;

  modport master (
    output instr_in, pc_in, valid_in, rdata1_in, rdata2_in, ctrl_in,
           wb_we, wb_dest, wb_data, flush,
    input  stall_out, ex_valid, ex_ctrl, ex_pc, ex_op1, ex_op2, ex_imm,
           ex_rs, ex_rt, ex_dest
  );

  modport slave (
    input  instr_in, pc_in, valid_in, rdata1_in, rdata2_in, ctrl_in,
           wb_we, wb_dest, wb_data, flush,
    output stall_out, ex_valid, ex_ctrl, ex_pc, ex_op1, ex_op2, ex_imm,
           ex_rs, ex_rt, ex_dest
  );

endinterface

// File: rtl/id_ex_register_hazard_unit.sv
// Load-use hazard detector: stalls IF/ID and PC while a load in EX feeds the
// instruction in ID. A taken branch suppresses the stall.
module hazard_unit
  import pipeline_pkg::*;
(
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              valid_in,
  input  logic              flush,
  output logic              stall_out
);

  logic hazard;

  // rt is compared even for opcodes that do not read it; the extra stalls are accepted.
  assign hazard = ex_valid && ex_mem_read && (ex_dest != '0) && valid_in &&
                  ((ex_dest == rs) || (ex_dest == rt));

  assign stall_out = hazard && !flush;

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with write-back bypass, load-use stall and
// branch flush to a bubble.
module id_ex_register
  import pipeline_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  id_ex_register_if.slave bus
);

  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] dest;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] op1_next;
  logic [DATA_W-1:0] op2_next;
  logic              stall;
  logic              bubble;
  logic              unused_opcode;

  assign rs   = bus.instr_in[RS_LSB +: REG_AW];
  assign rt   = bus.instr_in[RT_LSB +: REG_AW];
  assign rd   = bus.instr_in[RD_LSB +: REG_AW];
  assign dest = bus.ctrl_in[CTRL_REG_DST] ? rd : rt;
  assign imm  = sign_ext_imm(bus.instr_in[IMM_LSB +: IMM_W]);
  assign unused_opcode = ^bus.instr_in[31:26];

  // The register bank does not return a value written in the same cycle.
  assign op1_next = (bus.wb_we && (bus.wb_dest == rs) && (rs != '0)) ? bus.wb_data : bus.rdata1_in;
  assign op2_next = (bus.wb_we && (bus.wb_dest == rt) && (rt != '0)) ? bus.wb_data : bus.rdata2_in;

  hazard_unit u_hazard (
    .ex_valid    (bus.ex_valid),
    .ex_mem_read (bus.ex_ctrl[CTRL_MEM_READ]),
    .ex_dest     (bus.ex_dest),
    .rs          (rs),
    .rt          (rt),
    .valid_in    (bus.valid_in),
    .flush       (bus.flush),
    .stall_out   (stall)
  );

  assign bus.stall_out = stall;
  assign bubble        = bus.flush || stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_valid <= 1'b0;
      bus.ex_ctrl  <= BUBBLE_CTRL;
      bus.ex_pc    <= '0;
      bus.ex_op1   <= '0;
      bus.ex_op2   <= '0;
      bus.ex_imm   <= '0;
      bus.ex_rs    <= '0;
      bus.ex_rt    <= '0;
      bus.ex_dest  <= '0;
    end else if (bubble) begin
      bus.ex_valid <= 1'b0;
      bus.ex_ctrl  <= BUBBLE_CTRL;
    end else begin
      bus.ex_valid <= bus.valid_in;
      bus.ex_ctrl  <= bus.valid_in ? bus.ctrl_in : BUBBLE_CTRL;
      bus.ex_pc    <= bus.pc_in;
      bus.ex_op1   <= op1_next;
      bus.ex_op2   <= op2_next;
      bus.ex_imm   <= imm;
      bus.ex_rs    <= rs;
      bus.ex_rt    <= rt;
      bus.ex_dest  <= dest;
    end
  end

endmodule

// File: tb/tb_id_ex_register.sv
// Directed bench for id_ex_register: capture, load-use stall, $0 handling,
// write-back bypass, flush priority and asynchronous reset.
module tb_id_ex_register;
  import pipeline_pkg::*;

  localparam logic [7:0] CTRL_R  = 8'h86;  // reg_write, reg_dst, alu_op=10
  localparam logic [7:0] CTRL_LW = 8'hD8;  // reg_write, mem_read, mem_to_reg, alu_src

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  id_ex_register_if bus ();

  id_ex_register dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic valid, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [7:0] ctrl);
    bus.instr_in  = instr;
    bus.pc_in     = pc;
    bus.valid_in  = valid;
    bus.rdata1_in = r1;
    bus.rdata2_in = r2;
    bus.ctrl_in   = ctrl;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".stall"}, {31'd0, bus.stall_out}, 32'd0);
    check({tag, ".valid"}, {31'd0, bus.ex_valid}, 32'd0);
    check({tag, ".ctrl"},  {24'd0, bus.ex_ctrl}, 32'd0);
    check({tag, ".pc"},    bus.ex_pc, 32'd0);
    check({tag, ".op1"},   bus.ex_op1, 32'd0);
    check({tag, ".op2"},   bus.ex_op2, 32'd0);
    check({tag, ".imm"},   bus.ex_imm, 32'd0);
    check({tag, ".rs"},    {27'd0, bus.ex_rs}, 32'd0);
    check({tag, ".rt"},    {27'd0, bus.ex_rt}, 32'd0);
    check({tag, ".dest"},  {27'd0, bus.ex_dest}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 8'h00);
    bus.wb_we   = 1'b0;
    bus.wb_dest = '0;
    bus.wb_data = '0;
    bus.flush   = 1'b0;

    tick();
    tick();
    check_all_zero("reset_init");
    rst_n = 1'b1;

    // add $3,$1,$2
    drive(32'h0022_1820, 32'h0000_0104, 1'b1, 32'd5, 32'd7, CTRL_R);
    #1 check("add.stall_pre", {31'd0, bus.stall_out}, 32'd0);
    tick();
    check("add.op1",   bus.ex_op1, 32'd5);
    check("add.op2",   bus.ex_op2, 32'd7);
    check("add.dest",  {27'd0, bus.ex_dest}, 32'd3);
    check("add.valid", {31'd0, bus.ex_valid}, 32'd1);
    check("add.ctrl",  {24'd0, bus.ex_ctrl}, 32'h86);
    check("add.pc",    bus.ex_pc, 32'h0000_0104);
    check("add.imm",   bus.ex_imm, 32'h0000_1820);
    check("add.rs",    {27'd0, bus.ex_rs}, 32'd1);
    check("add.rt",    {27'd0, bus.ex_rt}, 32'd2);

    // lw $4,0($1) then add $5,$4,$2: one-cycle stall
    drive(32'h8C24_0000, 32'h0000_0108, 1'b1, 32'h100, 32'h0, CTRL_LW);
    #1 check("lw.stall_pre", {31'd0, bus.stall_out}, 32'd0);
    tick();
    check("lw.dest", {27'd0, bus.ex_dest}, 32'd4);
    check("lw.ctrl", {24'd0, bus.ex_ctrl}, 32'hD8);
    drive(32'h0082_2820, 32'h0000_010C, 1'b1, 32'h11, 32'h22, CTRL_R);
    #1 check("lu.stall", {31'd0, bus.stall_out}, 32'd1);
    tick();
    check("lu.bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("lu.bubble_ctrl",  {24'd0, bus.ex_ctrl}, 32'd0);
    check("lu.stall_drop",   {31'd0, bus.stall_out}, 32'd0);
    tick();
    check("lu.add_valid", {31'd0, bus.ex_valid}, 32'd1);
    check("lu.add_dest",  {27'd0, bus.ex_dest}, 32'd5);
    check("lu.add_op1",   bus.ex_op1, 32'h11);
    check("lu.add_ctrl",  {24'd0, bus.ex_ctrl}, 32'h86);

    // lw $0 in EX, consumer reads $0: no stall
    drive(32'h8C20_0000, 32'h0000_0110, 1'b1, 32'h100, 32'h0, CTRL_LW);
    tick();
    check("z.lw_dest", {27'd0, bus.ex_dest}, 32'd0);
    drive(32'h0002_2820, 32'h0000_0114, 1'b1, 32'h0, 32'h33, CTRL_R);
    #1 check("z.stall", {31'd0, bus.stall_out}, 32'd0);
    tick();
    check("z.valid", {31'd0, bus.ex_valid}, 32'd1);
    check("z.dest",  {27'd0, bus.ex_dest}, 32'd5);
    check("z.op2",   bus.ex_op2, 32'h33);

    // lw $6,-4($1) then add $7,$2,$6 (rt hazard) with flush: flush wins
    drive(32'h8C26_FFFC, 32'h0000_0118, 1'b1, 32'h200, 32'h0, CTRL_LW);
    tick();
    check("neg.imm",  bus.ex_imm, 32'hFFFF_FFFC);
    check("neg.dest", {27'd0, bus.ex_dest}, 32'd6);
    drive(32'h0046_3820, 32'h0000_011C, 1'b1, 32'h44, 32'h55, CTRL_R);
    #1 check("rt.stall", {31'd0, bus.stall_out}, 32'd1);
    bus.flush = 1'b1;
    #1 check("fl.stall", {31'd0, bus.stall_out}, 32'd0);
    tick();
    check("fl.valid", {31'd0, bus.ex_valid}, 32'd0);
    check("fl.ctrl",  {24'd0, bus.ex_ctrl}, 32'd0);
    check("fl.dest_hold", {27'd0, bus.ex_dest}, 32'd6);
    bus.flush = 1'b0;

    // WB bypass
    drive(32'h0022_1820, 32'h0000_0120, 1'b1, 32'd4, 32'd7, CTRL_R);
    bus.wb_we = 1'b1; bus.wb_dest = 5'd1; bus.wb_data = 32'hDEAD_BEEF;
    tick();
    check("byp.op1", bus.ex_op1, 32'hDEAD_BEEF);
    check("byp.op2", bus.ex_op2, 32'd7);
    bus.wb_dest = 5'd0;
    tick();
    check("byp.d0_op1", bus.ex_op1, 32'd4);
    drive(32'h0002_1820, 32'h0000_0124, 1'b1, 32'd4, 32'd7, CTRL_R);
    tick();
    check("byp.r0_op1", bus.ex_op1, 32'd4);
    drive(32'h0042_1820, 32'h0000_0128, 1'b1, 32'd9, 32'd10, CTRL_R);
    bus.wb_dest = 5'd2;
    tick();
    check("byp.both_op1", bus.ex_op1, 32'hDEAD_BEEF);
    check("byp.both_op2", bus.ex_op2, 32'hDEAD_BEEF);
    bus.wb_we = 1'b0;
    tick();
    check("byp.we0_op1", bus.ex_op1, 32'd9);
    check("byp.we0_op2", bus.ex_op2, 32'd10);

    // invalid ID slot: ctrl forced to zero
    drive(32'h0022_1820, 32'h0000_012C, 1'b0, 32'd1, 32'd2, CTRL_R);
    tick();
    check("inv.valid", {31'd0, bus.ex_valid}, 32'd0);
    check("inv.ctrl",  {24'd0, bus.ex_ctrl}, 32'd0);

    // reset asserted mid-stall
    drive(32'h8C24_0000, 32'h0000_0130, 1'b1, 32'h100, 32'h0, CTRL_LW);
    tick();
    drive(32'h0082_2820, 32'h0000_0134, 1'b1, 32'h11, 32'h22, CTRL_R);
    #1 check("rst.stall_pre", {31'd0, bus.stall_out}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_mid");
    tick();
    rst_n = 1'b1;
    #1 check("rst.stall_post", {31'd0, bus.stall_out}, 32'd0);
    tick();
    check("rst.load_valid", {31'd0, bus.ex_valid}, 32'd1);
    check("rst.load_dest",  {27'd0, bus.ex_dest}, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_register.md
# id_ex_register

Pipeline register between decode (ID) and execute (EX) in the 5-stage MIPS-subset core. Captures the two register-bank read operands, the decoded instruction fields and control bits on each clock edge. Contains load-use hazard detection, which stalls IF/ID and the PC. Also contains a write-back bypass for same-cycle register-bank writes. Branch resolution can flush it to a bubble.

## Interface
- DATA_W, 32, operand and PC width
- REG_AW, 5, register index width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- instr_in  in  32  instruction from IF/ID
- pc_in  in  DATA_W  PC+4 from IF/ID
- valid_in  in  1  IF/ID holds a real instruction
- rdata1_in, rdata2_in  in  DATA_W  register-bank read outputs for rs, rt
- ctrl_in  in  8  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[1:0]} from decoder
- wb_we  in  1  write-back stage writing the register bank this cycle
- wb_dest  in  REG_AW  write-back destination
- wb_data  in  DATA_W  write-back value
- flush  in  1  branch taken; kill the instruction entering EX
- stall_out  out  1  combinational; freeze PC and IF/ID
- ex_valid  out  1  EX holds a real instruction
- ex_ctrl  out  8  registered control bits
- ex_pc  out  DATA_W  registered PC+4
- ex_op1, ex_op2  out  DATA_W  registered operands
- ex_imm  out  DATA_W  sign-extended instr[15:0]
- ex_rs, ex_rt, ex_dest  out  REG_AW  source indices and destination index

## Operation
- Field extraction:
  - rs = instr_in[25:21], rt = [20:16], rd = [15:11].
  - dest = reg_dst ? rd : rt.
  - imm = {{16{instr_in[15]}}, instr_in[15:0]}.
- WB bypass for each source:
  - Condition: wb_we && wb_dest == src && src != 0.
  - When true, capture wb_data; otherwise capture rdata.
  - Needed because the register bank does not return a value written in the same cycle.
- Load-use hazard detection:
  - hazard = ex_valid && ex_ctrl.mem_read && ex_dest != 0 && valid_in && (ex_dest == rs || ex_dest == rt).
  - rt is compared for every opcode; conservative, accepted.
  - stall_out = hazard && !flush.
- Each clock edge, in priority order:
  1. flush: load bubble — ex_valid=0, ex_ctrl=0. Other fields are don't-care and hold their old value.
  2. hazard: load bubble, same as flush; IF/ID holds, so the instruction re-presents next cycle.
  3. otherwise: load all fields. ex_valid=valid_in. ex_ctrl=valid_in ? ctrl_in : 0.
- A bubble must never assert reg_write, mem_read or mem_write.
- Register 0 is never a hazard source and never a bypass target.

## Timing
- Reset (asynchronous assert, synchronous-edge release): all outputs 0, stall_out 0.
- Latency: 1 cycle, ID inputs to ex_* outputs.
- stall_out is purely combinational from current ex_* state and instr_in, in the same cycle. No registered path.
- A load-use stall lasts exactly 1 cycle. The next cycle EX holds a bubble, so hazard drops.
- flush and hazard in the same cycle:
  - flush wins and stall_out=0.
  - The killed ID instruction is replaced by the branch target fetch.
- wb_we to the same register as both rs and rt: both operands take wb_data.
- Reset asserted mid-stall: outputs clear immediately. No stall remains after release.

## Structure
- Shared package pipeline_pkg holds:
  - ctrl bit-position constants (CTRL_REG_WRITE … CTRL_ALU_OP);
  - field-slice constants for rs/rt/rd/imm;
  - the BUBBLE_CTRL value (8'h00).
- One sub-module, hazard_unit: purely combinational.
  - Inputs: ex_valid, ex_mem_read, ex_dest, rs, rt, valid_in, flush.
  - Output: stall_out.
- The bypass mux and the register process stay in id_ex_register.

## Test plan
- Reset:
  - Stimulus: assert rst_n=0 mid-cycle with ex_valid=1.
  - Response: all outputs 0 immediately; stall_out=0.
- Normal capture:
  - Stimulus: instr add $3,$1,$2 (0x00221820), rdata1=5, rdata2=7, ctrl reg_dst=1.
  - Response: next cycle ex_op1=5, ex_op2=7, ex_dest=3, ex_valid=1.
- Load-use stall:
  - Stimulus: lw $4,0($1) in EX, then add $5,$4,$2 in ID.
  - Response: stall_out=1 for exactly one cycle; EX gets a bubble with ctrl=0; the add enters EX the following cycle.
- $0 no-hazard:
  - Stimulus: lw $0 in EX, consumer reads $0.
  - Response: stall_out=0, no bubble.
- WB bypass:
  - Stimulus: wb_we=1, wb_dest=1, wb_data=0xDEADBEEF, rdata1=4, rs=1.
  - Response: ex_op1=0xDEADBEEF.
  - Repeat with wb_dest=0: ex_op1=4.
- Flush vs hazard:
  - Stimulus: flush=1 while a load-use condition is present.
  - Response: stall_out=0; next cycle ex_valid=0, ex_ctrl=0.
